// File: rtl/addition_stage3.sv
// addition_stage3: adds or subtracts the aligned mantissas of two floating-point operands and registers the result behind a valid/ready handshake.
// Optional feature: define ADD_STAGE3_SKID_EN to add a one-entry skid register, which makes in_ready a registered "skid empty" flag.
module addition_stage3 #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MENT_WIDTH-1:0] larger_operand_in,
  input  logic [MENT_WIDTH:0]   smaller_operand_in,
  input  logic                  larger_sign_in,
  input  logic                  smaller_sign_in,
  input  logic [EXPO_WIDTH-1:0] exponent_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MENT_WIDTH+1:0] mentissa_sum_out,
  output logic [EXPO_WIDTH-1:0] exponent_out,
  output logic                  sign_out,
  output logic                  zero_out
);

  localparam int SUM_W = MENT_WIDTH + 2;

  typedef struct packed {
    logic [SUM_W-1:0]      sum;
    logic [EXPO_WIDTH-1:0] expo;
    logic                  sign;
    logic                  zero;
  } result_t;

  logic [MENT_WIDTH:0] opA;
  logic [MENT_WIDTH:0] opB;
  logic [SUM_W-1:0]    rawSum;
  logic                rawSign;
  result_t             newResult;
  result_t             out_q;
  result_t             out_d;
  logic                outValid_q;
  logic                outValid_d;
  logic                accept;

  assign opA = {1'b1, larger_operand_in};
  assign opB = smaller_operand_in;

  // B can only exceed A when the exponents were equal, so the sign then follows the smaller operand.
  always_comb begin
    rawSum  = '0;
    rawSign = larger_sign_in;
    if (larger_sign_in == smaller_sign_in) begin
      rawSum = {1'b0, opA} + {1'b0, opB};
    end else if (opA >= opB) begin
      rawSum = {1'b0, opA - opB};
    end else begin
      rawSum  = {1'b0, opB - opA};
      rawSign = smaller_sign_in;
    end
    newResult.sum  = rawSum;
    newResult.expo = exponent_in;
    newResult.zero = (rawSum == '0);
    newResult.sign = rawSign && (rawSum != '0);
  end

  assign accept           = in_valid && in_ready;
  assign out_valid        = outValid_q;
  assign mentissa_sum_out = out_q.sum;
  assign exponent_out     = out_q.expo;
  assign sign_out         = out_q.sign;
  assign zero_out         = out_q.zero;

`ifdef ADD_STAGE3_SKID_EN

  result_t skid_q;
  result_t skid_d;
  logic    skidValid_q;
  logic    skidValid_d;
  logic    outFree;

  assign outFree  = !outValid_q || out_ready;
  assign in_ready = !rst && !skidValid_q;

  // A parked skid entry always has priority over fresh input so ordering is kept.
  always_comb begin
    out_d       = out_q;
    outValid_d  = outValid_q;
    skid_d      = skid_q;
    skidValid_d = skidValid_q;
    if (outFree) begin
      if (skidValid_q) begin
        out_d       = skid_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
      end else if (accept) begin
        out_d      = newResult;
        outValid_d = 1'b1;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = newResult;
      skidValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      outValid_q  <= 1'b0;
      skid_q      <= '0;
      skidValid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      outValid_q  <= outValid_d;
      skid_q      <= skid_d;
      skidValid_q <= skidValid_d;
    end
  end

`else

  assign in_ready = !rst && (!outValid_q || out_ready);

  always_comb begin
    out_d      = out_q;
    outValid_d = outValid_q;
    if (accept) begin
      out_d      = newResult;
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      outValid_q <= outValid_d;
    end
  end

`endif

endmodule

// File: tb/tb_addition_stage3.sv
// Directed testbench for addition_stage3: hand-computed vectors, backpressure, streaming and reset-during-stall.
// Handles both the default build and the ADD_STAGE3_SKID_EN build.
module tb_addition_stage3;

  localparam int MW = 23;
  localparam int EW = 8;

`ifdef ADD_STAGE3_SKID_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif

  typedef struct packed {
    logic [MW-1:0] larger;
    logic [MW:0]   smaller;
    logic          ls;
    logic          ss;
    logic [EW-1:0] expo;
    logic [MW+1:0] sum;
    logic          sign;
    logic          zero;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] larger_operand_in;
  logic [MW:0]   smaller_operand_in;
  logic          larger_sign_in;
  logic          smaller_sign_in;
  logic [EW-1:0] exponent_in;
  logic          out_valid;
  logic          out_ready;
  logic [MW+1:0] mentissa_sum_out;
  logic [EW-1:0] exponent_out;
  logic          sign_out;
  logic          zero_out;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   popped = 0;
  vec_t expQ[$];

  addition_stage3 #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .larger_operand_in(larger_operand_in), .smaller_operand_in(smaller_operand_in),
    .larger_sign_in(larger_sign_in), .smaller_sign_in(smaller_sign_in),
    .exponent_in(exponent_in), .out_valid(out_valid), .out_ready(out_ready),
    .mentissa_sum_out(mentissa_sum_out), .exponent_out(exponent_out),
    .sign_out(sign_out), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic vec_t hv(input logic [MW-1:0] l, input logic [MW:0] s, input logic ls,
                              input logic ss, input logic [EW-1:0] e, input logic [MW+1:0] sum,
                              input logic sign, input logic zero);
    vec_t v;
    v.larger = l; v.smaller = s; v.ls = ls; v.ss = ss; v.expo = e;
    v.sum = sum; v.sign = sign; v.zero = zero;
    return v;
  endfunction

  // Reference: treat each operand as a signed integer, add, then split into sign and magnitude.
  function automatic vec_t makeVec(input logic [MW-1:0] l, input logic [MW:0] s, input logic ls,
                                   input logic ss, input logic [EW-1:0] e);
    vec_t   v;
    longint a;
    longint b;
    longint r;
    a = 0; a[MW:0] = {1'b1, l};
    b = 0; b[MW:0] = s;
    if (ls) a = -a;
    if (ss) b = -b;
    r = a + b;
    v.larger = l; v.smaller = s; v.ls = ls; v.ss = ss; v.expo = e;
    v.sign = (r < 0);
    v.zero = (r == 0);
    v.sum  = (r < 0) ? (MW+2)'(-r) : (MW+2)'(r);
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input vec_t vec, input logic ordy);
    in_valid           = v;
    larger_operand_in  = vec.larger;
    smaller_operand_in = vec.smaller;
    larger_sign_in     = vec.ls;
    smaller_sign_in    = vec.ss;
    exponent_in        = vec.expo;
    out_ready          = ordy;
  endtask

  // One clock of traffic: drive, score any output handshake, record any input handshake, advance.
  task automatic runCycle(input logic v, input vec_t vec, input logic ordy, output logic accepted);
    vec_t e;
    applyStimulus(v, vec, ordy);
    #1;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResult", 64'(out_valid), 64'd0);
      end else begin
        e = expQ.pop_front();
        popped++;
        checkOutput("sum", 64'(mentissa_sum_out), 64'(e.sum));
        checkOutput("sign", 64'(sign_out), 64'(e.sign));
        checkOutput("zero", 64'(zero_out), 64'(e.zero));
        checkOutput("exponent", 64'(exponent_out), 64'(e.expo));
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) expQ.push_back(vec);
    @(posedge clk);
    #1;
  endtask

  vec_t dirVec[7];
  vec_t bpVec[3];
  vec_t rv;
  logic acc;
  int   offered;
  int   accCount;
  int   guard;
  int   popStart;

  initial begin
    dirVec[0] = hv(23'h400000, 24'hC00000, 1'b0, 1'b0, 8'h7F, 25'h1800000, 1'b0, 1'b0);
    dirVec[1] = hv(23'h000000, 24'h800000, 1'b0, 1'b1, 8'h80, 25'h0000000, 1'b0, 1'b1);
    dirVec[2] = hv(23'h000000, 24'hC00000, 1'b0, 1'b1, 8'h81, 25'h0400000, 1'b1, 1'b0);
    dirVec[3] = hv(23'h000001, 24'h000001, 1'b1, 1'b1, 8'h10, 25'h0800002, 1'b1, 1'b0);
    dirVec[4] = hv(23'h200000, 24'h100000, 1'b1, 1'b0, 8'h22, 25'h0900000, 1'b1, 1'b0);
    dirVec[5] = hv(23'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0, 8'hFE, 25'h1FFFFFE, 1'b0, 1'b0);
    dirVec[6] = hv(23'h000000, 24'h800000, 1'b1, 1'b0, 8'h01, 25'h0000000, 1'b0, 1'b1);

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, dirVec[0], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("resetReady", 64'(in_ready), 64'd0);
    checkOutput("resetValid", 64'(out_valid), 64'd0);
    checkOutput("resetSum", 64'(mentissa_sum_out), 64'd0);
    checkOutput("resetExp", 64'(exponent_out), 64'd0);
    checkOutput("resetSign", 64'(sign_out), 64'd0);
    checkOutput("resetZero", 64'(zero_out), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("readyAfterReset", 64'(in_ready), 64'd1);

    // Directed arithmetic vectors, back to back with the output always ready
    for (int i = 0; i < 7; i++) begin
      runCycle(1'b1, dirVec[i], 1'b1, acc);
      checkOutput("dirAccept", 64'(acc), 64'd1);
      checkOutput("dirLatency", 64'(out_valid), 64'd1);
    end
    runCycle(1'b0, dirVec[0], 1'b1, acc);
    checkOutput("dirDrop", 64'(out_valid), 64'd0);
    checkOutput("dirAllOut", 64'(expQ.size()), 64'd0);

    // Backpressure: three sets offered while the output is stalled
    bpVec[0] = dirVec[3]; bpVec[1] = dirVec[4]; bpVec[2] = dirVec[5];
    offered = 0; accCount = 0; popStart = popped;
    for (int c = 0; c < 3; c++) begin
      runCycle(1'b1, bpVec[offered], 1'b0, acc);
      if (acc) begin offered++; accCount++; end
      checkOutput("stallValid", 64'(out_valid), 64'd1);
      checkOutput("stallHold", 64'(mentissa_sum_out), 64'(bpVec[0].sum));
    end
    checkOutput("stallAccepted", 64'(accCount), 64'(STALL_ACCEPTS));
    checkOutput("stallReady", 64'(in_ready), 64'd0);
    guard = 0;
    while ((offered < 3 || expQ.size() > 0) && guard < 20) begin
      runCycle(offered < 3, bpVec[(offered < 3) ? offered : 0], 1'b1, acc);
      if (acc) offered++;
      guard++;
    end
    checkOutput("drainBound", 64'(guard < 20), 64'd1);
    checkOutput("drainCount", 64'(popped - popStart), 64'd3);
    runCycle(1'b0, bpVec[0], 1'b1, acc);
    checkOutput("drainIdle", 64'(out_valid), 64'd0);

    // Streaming: sixteen random sets, one per cycle
    popStart = popped;
    for (int i = 0; i < 16; i++) begin
      rv = makeVec(MW'($urandom), (MW+1)'($urandom), 1'($urandom), 1'($urandom), EW'($urandom));
      runCycle(1'b1, rv, 1'b1, acc);
      checkOutput("streamAccept", 64'(acc), 64'd1);
      checkOutput("streamValid", 64'(out_valid), 64'd1);
    end
    runCycle(1'b0, rv, 1'b1, acc);
    checkOutput("streamCount", 64'(popped - popStart), 64'd16);
    checkOutput("streamIdle", 64'(out_valid), 64'd0);

    // Reset while stalled with held results
    offered = 0;
    for (int c = 0; c < 3; c++) begin
      runCycle(1'b1, dirVec[offered], 1'b0, acc);
      if (acc) offered++;
    end
    checkOutput("preResetAccepted", 64'(offered), 64'(STALL_ACCEPTS));
    applyStimulus(1'b1, dirVec[2], 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midResetReady", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    expQ.delete();
    checkOutput("midResetValid", 64'(out_valid), 64'd0);
    checkOutput("midResetSum", 64'(mentissa_sum_out), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, dirVec[0], 1'b1);
    #1;
    checkOutput("postResetReady", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      runCycle(1'b0, dirVec[0], 1'b1, acc);
      checkOutput("noStale", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
